// File: rtl/fp8_pkg.sv
// Shared FP16 / FP8 E5M2 field widths, encodings and lane flag bundle.
// Imported by the lane converter and the pipeline wrapper.
package fp8_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int E5M2_EXP_W = 5;
  localparam int E5M2_MAN_W = 2;
  localparam int EXP_BIAS   = 15;

  localparam logic [6:0] E5M2_QNAN_MAG = 7'h7E;
  localparam logic [6:0] E5M2_INF_MAG  = 7'h7C;
  localparam logic [6:0] E5M2_MAXF_MAG = 7'h7B;

  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
    logic nan;
  } lane_flags_t;

endpackage

// File: rtl/fp16_to_e5m2_lane.sv
// Combinational FP16 -> E5M2 converter, round-to-nearest-even.
// fp16 in, e5m2 byte + lane flags out; FP8_SATURATE_EN clamps overflow.
module fp16_to_e5m2_lane
  import fp8_pkg::*;
(
  input  logic [15:0] fp16,
  output logic [7:0]  e5m2,
  output lane_flags_t flags
);

  localparam int RW = E5M2_EXP_W + E5M2_MAN_W;

  logic                  s;
  logic [FP16_EXP_W-1:0] e;
  logic [FP16_MAN_W-1:0] m;
  logic                  lsb;
  logic                  guard;
  logic                  sticky;
  logic                  rnd_up;
  logic [RW-1:0]         sum;
  logic                  is_nan;
  logic                  is_inf;
  logic                  is_ovf;

  assign {s, e, m} = fp16;

  assign lsb    = m[8];
  assign guard  = m[7];
  assign sticky = |m[6:0];
  assign rnd_up = guard & (sticky | lsb);

  // Mantissa carry ripples into the exponent, so
  // subnormals can round up into the normal range.
  assign sum = {e, m[9:8]} + {{(RW-1){1'b0}}, rnd_up};

  assign is_nan = (&e) & (|m);
  assign is_inf = (&e) & ~(|m);
  assign is_ovf = ~(&e) & (&sum[RW-1:E5M2_MAN_W]);

  always_comb begin
    e5m2  = '0;
    flags = '0;
    unique case (1'b1)
      is_nan: begin
        e5m2      = {s, E5M2_QNAN_MAG};
        flags.nan = 1'b1;
      end
      is_inf: begin
        e5m2 = {s, E5M2_INF_MAG};
      end
      is_ovf: begin
`ifdef FP8_SATURATE_EN
        e5m2      = {s, E5M2_MAXF_MAG};
`else
        e5m2      = {s, E5M2_INF_MAG};
`endif
        flags.ovf = 1'b1;
        flags.inx = 1'b1;
      end
      default: begin
        e5m2      = {s, sum};
        flags.inx = guard | sticky;
        flags.unf = (|fp16[14:0]) & ~(|sum);
      end
    endcase
  end

endmodule

// File: rtl/fp16_to_fp8e5m2_pipe.sv
// 2-stage valid/ready FP16 -> E5M2 lane converter with sticky flags.
// in/out handshake, flag_clr, flag_*, beat_cnt; FP8_SATURATE_EN optional.
module fp16_to_fp8e5m2_pipe
  import fp8_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*LANES-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*LANES-1:0]   out_data,
  input  logic                 flag_clr,
  output logic                 flag_ovf,
  output logic                 flag_unf,
  output logic                 flag_inx,
  output logic                 flag_nan,
  output logic [CNT_W-1:0]     beat_cnt
);

  logic                s1_valid;
  logic                s2_valid;
  logic                s1_adv;
  logic                s2_adv;
  logic                s2_load;
  logic                acc;
  logic [16*LANES-1:0] s1_data;
  logic [8*LANES-1:0]  cvt;
  lane_flags_t         lf [LANES];
  lane_flags_t         any_f;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;
  assign acc      = in_valid & s1_adv;
  assign s2_load  = s2_adv & s1_valid;

  assign out_valid = s2_valid;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp16_to_e5m2_lane u_lane (
      .fp16  (s1_data[16*i +: 16]),
      .e5m2  (cvt[8*i +: 8]),
      .flags (lf[i])
    );
  end

  always_comb begin
    any_f = '0;
    for (int i = 0; i < LANES; i++) begin
      any_f.ovf |= lf[i].ovf;
      any_f.unf |= lf[i].unf;
      any_f.inx |= lf[i].inx;
      any_f.nan |= lf[i].nan;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) s1_data <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) out_data <= cvt;
    end
  end

  // A flag event in the clearing cycle still lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_ovf <= 1'b0;
      flag_unf <= 1'b0;
      flag_inx <= 1'b0;
      flag_nan <= 1'b0;
    end else begin
      flag_ovf <= (flag_ovf & ~flag_clr) | (s2_load & any_f.ovf);
      flag_unf <= (flag_unf & ~flag_clr) | (s2_load & any_f.unf);
      flag_inx <= (flag_inx & ~flag_clr) | (s2_load & any_f.inx);
      flag_nan <= (flag_nan & ~flag_clr) | (s2_load & any_f.nan);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else begin
      beat_cnt <= (flag_clr ? '0 : beat_cnt) + CNT_W'(acc);
    end
  end

endmodule

// File: tb/tb_fp16_to_fp8e5m2_pipe.sv
// Self-checking bench for fp16_to_fp8e5m2_pipe.
// Reference rounds by nearest-value search over all E5M2 codes.
module tb_fp16_to_fp8e5m2_pipe;

  localparam int LANES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        flag_clr = 1'b0;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_inx;
  logic        flag_nan;
  logic [15:0] beat_cnt;

  fp16_to_fp8e5m2_pipe #(.LANES(LANES), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .flag_clr  (flag_clr),
    .flag_ovf  (flag_ovf),
    .flag_unf  (flag_unf),
    .flag_inx  (flag_inx),
    .flag_nan  (flag_nan),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] b;
    logic [3:0]  f;
  } exp_t;

  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [3:0]  f_m = '0;
  logic [15:0] cnt_m = '0;
  logic        bp_mode = 1'b0;
  int          cyc = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic [31:0] last_out = '0;
  int          tp_acc = 0;
  int          tp_out = 0;
  int          rdy_low = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Magnitude of an E5M2 code in units of 2^-24; code 124 stands
  // for the first unrepresentable step (2^16) so ties go to even.
  function automatic longint val8(input int c);
    int e;
    int mm;
    e  = c >> 2;
    mm = c & 3;
    if (e == 0) return longint'(mm) << 8;
    return longint'(4 + mm) << (e + 7);
  endfunction

  function automatic void ref_lane(input logic [15:0] x,
                                   output logic [7:0] b,
                                   output logic [3:0] f);
    logic   s;
    int     e;
    int     m;
    longint v;
    longint d;
    longint bd;
    longint cv;
    int     best;
    s = x[15];
    e = int'(x[14:10]);
    m = int'(x[9:0]);
    if (e == 31) begin
      b = (m != 0) ? {s, 7'h7E} : {s, 7'h7C};
      f = (m != 0) ? 4'b0001 : 4'b0000;
      return;
    end
    v = (e == 0) ? longint'(m) : longint'(1024 + m) << (e - 1);
    best = 0;
    bd   = v;
    for (int c = 1; c <= 124; c++) begin
      cv = val8(c);
      d  = (cv > v) ? cv - v : v - cv;
      if (d < bd || (d == bd && (c % 2) == 0)) begin
        best = c;
        bd   = d;
      end
      if (cv > v) break;
    end
    f = {best == 124, v != 0 && best == 0, val8(best) != v, 1'b0};
`ifdef FP8_SATURATE_EN
    if (best == 124) best = 123;
`endif
    b = {s, 7'(best)};
  endfunction

  function automatic exp_t ref_beat(input logic [63:0] d);
    exp_t       r;
    logic [7:0] b;
    logic [3:0] f;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      ref_lane(d[16*i +: 16], b, f);
      r.b[8*i +: 8] = b;
      r.f = r.f | f;
    end
    return r;
  endfunction

  always @(posedge clk) cyc++;

  // Transfers seen here complete at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (flag_clr) begin
        f_m   = '0;
        cnt_m = '0;
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (out_valid && !prev_stall && q.size() > 0) f_m = f_m | q[0].f;
      if (out_valid && out_ready) begin
        chk("out_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          exp_t e;
          e = q.pop_front();
          chk("data", out_data, e.b);
        end
        last_out = out_data;
        if (tp_out < 0) tp_out = cyc;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_beat(in_data));
        cnt_m++;
        if (tp_acc < 0) tp_acc = cyc;
      end
      chk("depth", q.size() <= 2, 1);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_mode) out_ready = ($urandom % 2) == 1;
    #1;
  endtask

  task automatic send(input logic [63:0] d);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 1000; t++) begin
      acc = in_ready;
      if (!acc) rdy_low++;
      tick();
      if (acc) return;
    end
    chk("send_timeout", acc, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (q.size() == 0 && !out_valid) return;
      tick();
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  task automatic clr();
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_flags"}, {flag_ovf, flag_unf, flag_inx, flag_nan}, f_m);
    chk({tag, "_cnt"}, beat_cnt, cnt_m);
  endtask

  task automatic dir(input logic [15:0] x, input logic [7:0] eb,
                     input logic [3:0] ef);
    clr();
    send({4{x}});
    drain();
    chk($sformatf("byte_%h", x), last_out[7:0], eb);
    chk($sformatf("flags_%h", x),
        {flag_ovf, flag_unf, flag_inx, flag_nan}, ef);
  endtask

  function automatic logic [63:0] rnd_beat();
    logic [63:0] d;
    logic [15:0] l;
    for (int i = 0; i < LANES; i++) begin
      l = 16'($urandom);
      case ($urandom % 8)
        0: l[14:10] = 5'd30;
        1: l[14:10] = 5'd31;
        2: l[14:10] = 5'd0;
        default: ;
      endcase
      d[16*i +: 16] = l;
    end
    return d;
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {flag_ovf, flag_unf, flag_inx, flag_nan}, 0);
    chk("rst_cnt", beat_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    dir(16'h3C00, 8'h3C, 4'b0000);
    dir(16'h3D00, 8'h3D, 4'b0000);
    dir(16'h3C80, 8'h3C, 4'b0010);
    dir(16'h3D80, 8'h3E, 4'b0010);
`ifdef FP8_SATURATE_EN
    dir(16'h7B80, 8'h7B, 4'b1010);
`else
    dir(16'h7B80, 8'h7C, 4'b1010);
`endif
    dir(16'hFC00, 8'hFC, 4'b0000);
    dir(16'h7C01, 8'h7E, 4'b0001);
    dir(16'hFE00, 8'hFE, 4'b0001);
    dir(16'h0001, 8'h00, 4'b0110);
    dir(16'h03FF, 8'h04, 4'b0010);
    dir(16'h8000, 8'h80, 4'b0000);

    clr();
    for (int i = 0; i < 50; i++) send(rnd_beat());
    drain();
    chk_state("mixed");

    clr();
    tp_acc = -1;
    tp_out = -1;
    rdy_low = 0;
    for (int i = 0; i < 100; i++) send(rnd_beat());
    drain();
    chk("tp_in_ready_drop", rdy_low, 0);
    chk("tp_latency", tp_out - tp_acc, 2);
    chk("tp_cnt", beat_cnt, 100);
    chk_state("tp");

    clr();
    bp_mode = 1'b1;
    rdy_low = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) idle(1);
      send(rnd_beat());
    end
    drain();
    bp_mode = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_ready_dropped", rdy_low > 0, 1);
    chk_state("bp");

    clr();
    out_ready = 1'b0;
    send({4{16'h7C01}});
    send(rnd_beat());
    in_valid = 1'b0;
    rst_n = 1'b0;
    q.delete();
    f_m = '0;
    cnt_m = '0;
    #2;
    chk("arst_out_valid", out_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_flags", {flag_ovf, flag_unf, flag_inx, flag_nan}, 0);
    chk("post_rst_cnt", beat_cnt, 0);
    out_ready = 1'b1;
    idle(5);
    chk("post_rst_no_out", out_valid, 0);

    clr();
    send({4{16'h0001}});
    drain();
    chk("pre_clr_unf", flag_unf, 1);
    send({4{16'h7B80}});
    in_valid = 1'b0;
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    drain();
    chk("clr_vs_ovf", {flag_ovf, flag_unf, flag_inx, flag_nan}, 4'b1010);
    chk_state("clr_vs_ovf");

    flag_clr = 1'b1;
    send(rnd_beat());
    flag_clr = 1'b0;
    drain();
    chk("clr_plus_inc", beat_cnt, 1);

    clr();
    for (int i = 0; i < 65535; i++) send(rnd_beat());
    chk("cnt_max", beat_cnt, 16'hFFFF);
    send(rnd_beat());
    drain();
    chk("cnt_wrap", beat_cnt, 0);
    chk_state("wrap");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
